// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, multiply/divide timeout, counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // Controller states; the encodings are fixed so that debug taps and other
    // pipeline blocks can decode the state register directly.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Number of MD_WAIT cycles allowed before the multiply/divide unit is
    // declared hung.
    localparam int unsigned MD_TIMER_W  = 6;
    localparam logic [MD_TIMER_W-1:0] MD_TIMEOUT = 6'd40;

    // Width of the stall performance counter.
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/perf_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
// Latency: count reflects an inc sampled on the previous rising edge.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk, rst (async active-high), clr (sync clear), inc (count enable),
//        count [W-1:0] (current value).
module perf_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for memory waits, multi-cycle multiply/divide and hazards.
// Latency: stall/flush outputs are combinational in RUN; md_go/md_err/stall_cycles are registered.
// Backpressure: mem_busy holds the whole front of the pipe and bubbles MEM/WB until it clears.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   hdu_block, branch_taken   hazard block and taken-branch from ID
//   md_start, md_done         multiply/divide launch request (EX) and completion pulse
//   mem_busy                  data memory not ready this cycle
//   perf_clr                  synchronous clear of stall_cycles
//   PcStall .. EX_MEM_Stall   hold PC / pipeline registers
//   IF_ID_Flush .. MEM_WB_Flush  load bubbles
//   md_go, md_err             MD start pulse, sticky MD timeout flag
//   stall_cycles              saturating count of PcStall cycles
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hdu_block,
    input  logic                   branch_taken,
    input  logic                   md_start,
    input  logic                   md_done,
    input  logic                   mem_busy,
    input  logic                   perf_clr,
    output logic                   PcStall,
    output logic                   IF_ID_Stall,
    output logic                   ID_EX_Stall,
    output logic                   EX_MEM_Stall,
    output logic                   IF_ID_Flush,
    output logic                   ID_EX_Flush,
    output logic                   MEM_WB_Flush,
    output logic                   md_go,
    output logic                   md_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [MD_TIMER_W-1:0] TIMER_ONE = {{(MD_TIMER_W-1){1'b0}}, 1'b1};

    state_e                state_q,     state_d;
    logic                  done_pend_q, done_pend_d;
    logic [MD_TIMER_W-1:0] md_timer_q,  md_timer_d;
    logic                  md_go_q,     md_go_d;
    logic                  md_err_q,    md_err_d;

    logic pc_stall_c;
    logic if_id_stall_c;
    logic id_ex_stall_c;
    logic ex_mem_stall_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic mem_wb_flush_c;
    logic md_fin_c;

    // A completion is either the live pulse or one that arrived while memory
    // was busy and had to be parked.
    assign md_fin_c = md_done | done_pend_q;

    always_comb begin
        state_d        = state_q;
        done_pend_d    = 1'b0;
        md_timer_d     = md_timer_q;
        md_go_d        = 1'b0;
        md_err_d       = md_err_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_stall_c  = 1'b0;
        ex_mem_stall_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        mem_wb_flush_c = 1'b0;

        case (state_q)
            RUN: begin
                md_timer_d = '0;
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    mem_wb_flush_c = 1'b1;
                    state_d        = MEM_WAIT;
                end else if (md_start) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_stall_c = 1'b1;
                    md_go_d       = 1'b1;
                    state_d       = MD_WAIT;
                end else if (hdu_block) begin
                    // A blocked branch is re-evaluated next cycle, so it must
                    // not flush IF/ID yet.
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                pc_stall_c     = 1'b1;
                if_id_stall_c  = 1'b1;
                id_ex_stall_c  = 1'b1;
                ex_mem_stall_c = 1'b1;
                mem_wb_flush_c = 1'b1;
                if (!mem_busy) begin
                    state_d = RUN;
                end
            end

            MD_WAIT: begin
                pc_stall_c     = 1'b1;
                if_id_stall_c  = 1'b1;
                id_ex_stall_c  = 1'b1;
                // The older instruction in MEM still needs the memory, so only
                // EX/MEM is held while it is busy; nothing is bubbled.
                ex_mem_stall_c = mem_busy;
                if (md_timer_q != MD_TIMEOUT) begin
                    md_timer_d = md_timer_q + TIMER_ONE;
                end
                if (md_fin_c) begin
                    if (!mem_busy) begin
                        state_d = RUN;
                    end else begin
                        done_pend_d = 1'b1;
                    end
                end else if ((md_timer_q + TIMER_ONE) == MD_TIMEOUT) begin
                    md_err_d = 1'b1;
                    state_d  = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            done_pend_q <= 1'b0;
            md_timer_q  <= '0;
            md_go_q     <= 1'b0;
            md_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
            md_timer_q  <= md_timer_d;
            md_go_q     <= md_go_d;
            md_err_q    <= md_err_d;
        end
    end

    // Gate with rst so that a reset that lands while inputs are still active
    // quiets the pipeline controls immediately, not at the next edge.
    assign PcStall      = pc_stall_c     & ~rst;
    assign IF_ID_Stall  = if_id_stall_c  & ~rst;
    assign ID_EX_Stall  = id_ex_stall_c  & ~rst;
    assign EX_MEM_Stall = ex_mem_stall_c & ~rst;
    assign IF_ID_Flush  = if_id_flush_c  & ~rst;
    assign ID_EX_Flush  = id_ex_flush_c  & ~rst;
    assign MEM_WB_Flush = mem_wb_flush_c & ~rst;
    assign md_go        = md_go_q;
    assign md_err       = md_err_q;

    perf_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (PcStall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: RUN decode table, directed multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        hdu_block;
    logic        branch_taken;
    logic        md_start;
    logic        md_done;
    logic        mem_busy;
    logic        perf_clr;
    logic        PcStall;
    logic        IF_ID_Stall;
    logic        ID_EX_Stall;
    logic        EX_MEM_Stall;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        MEM_WB_Flush;
    logic        md_go;
    logic        md_err;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // {PcStall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}
    logic [6:0] outs;
    assign outs = {PcStall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall,
                   IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush};

    pipeline_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .hdu_block    (hdu_block),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_done      (md_done),
        .mem_busy     (mem_busy),
        .perf_clr     (perf_clr),
        .PcStall      (PcStall),
        .IF_ID_Stall  (IF_ID_Stall),
        .ID_EX_Stall  (ID_EX_Stall),
        .EX_MEM_Stall (EX_MEM_Stall),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .MEM_WB_Flush (MEM_WB_Flush),
        .md_go        (md_go),
        .md_err       (md_err),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic set_in(input logic h, input logic b, input logic s,
                          input logic d, input logic m, input logic c);
        @(negedge clk);
        hdu_block    = h;
        branch_taken = b;
        md_start     = s;
        md_done      = d;
        mem_busy     = m;
        perf_clr     = c;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        hdu_block = 0; branch_taken = 0; md_start = 0; md_done = 0; mem_busy = 0; perf_clr = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    bit m_in_mem;
    bit m_in_md;
    int m_md_cycles;
    bit m_pend;
    bit m_go;
    bit m_err;
    int m_cnt;

    task automatic model_reset();
        m_in_mem = 0; m_in_md = 0; m_md_cycles = 0; m_pend = 0;
        m_go = 0; m_err = 0; m_cnt = 0;
    endtask

    function automatic logic [6:0] model_outs(input bit h, input bit b, input bit s, input bit m);
        if (m_in_mem)  return 7'b1111001;
        if (m_in_md)   return {3'b111, m, 3'b000};
        if (m)         return 7'b1111001;
        if (s)         return 7'b1110000;
        if (h)         return 7'b1100010;
        if (b)         return 7'b0000100;
        return 7'b0000000;
    endfunction

    task automatic model_edge(input bit h, input bit b, input bit s, input bit d,
                              input bit m, input bit c);
        logic [6:0] o;
        bit go_next;
        o = model_outs(h, b, s, m);
        if (c) m_cnt = 0;
        else if (o[6] && m_cnt < 65535) m_cnt++;
        go_next = 0;
        if (m_in_mem) begin
            if (!m) m_in_mem = 0;
        end else if (m_in_md) begin
            m_md_cycles++;
            if (d || m_pend) begin
                if (!m) begin m_in_md = 0; m_pend = 0; end
                else m_pend = 1;
            end else if (m_md_cycles == 40) begin
                m_err = 1; m_in_md = 0;
            end
        end else if (m) begin
            m_in_mem = 1;
        end else if (s) begin
            m_in_md = 1; m_md_cycles = 0; m_pend = 0; go_next = 1;
        end
        m_go = go_next;
    endtask

    // ---------------- RUN decode table ----------------
    typedef struct {
        logic       h;
        logic       b;
        logic       s;
        logic       m;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int pc_cnt;
        rst = 1'b1;
        hdu_block = 0; branch_taken = 0; md_start = 0; md_done = 0; mem_busy = 0; perf_clr = 0;

        vecs[0] = '{h:0, b:0, s:0, m:0, exp:7'b0000000};
        vecs[1] = '{h:0, b:1, s:0, m:0, exp:7'b0000100};
        vecs[2] = '{h:1, b:0, s:0, m:0, exp:7'b1100010};
        vecs[3] = '{h:1, b:1, s:0, m:0, exp:7'b1100010};
        vecs[4] = '{h:0, b:0, s:1, m:0, exp:7'b1110000};
        vecs[5] = '{h:1, b:1, s:1, m:0, exp:7'b1110000};
        vecs[6] = '{h:0, b:0, s:0, m:1, exp:7'b1111001};
        vecs[7] = '{h:1, b:1, s:1, m:1, exp:7'b1111001};
        vecs[8] = '{h:0, b:1, s:1, m:0, exp:7'b1110000};
        vecs[9] = '{h:0, b:1, s:0, m:1, exp:7'b1111001};

        // Reset state
        #3;
        check("reset_outs", {25'd0, outs}, 32'd0);
        check("reset_md_go", {31'd0, md_go}, 32'd0);
        check("reset_md_err", {31'd0, md_err}, 32'd0);
        check("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_reset();
            set_in(vecs[i].h, vecs[i].b, vecs[i].s, 0, vecs[i].m, 0);
            check($sformatf("run_vec%0d", i), {25'd0, outs}, {25'd0, vecs[i].exp});
        end

        // hdu_block + branch_taken: stays in RUN, no flush of IF/ID
        do_reset();
        set_in(1, 1, 0, 0, 0, 0);
        check("hdu_br_outs", {25'd0, outs}, {25'd0, 7'b1100010});
        set_in(0, 0, 0, 0, 0, 0);
        check("hdu_br_next_run", {25'd0, outs}, 32'd0);

        // md_start, md_done 5 cycles later
        do_reset();
        set_in(0, 0, 1, 0, 0, 0);
        pc_cnt = int'(PcStall);
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 0, (k == 5), 0, 0);
            pc_cnt += int'(PcStall);
            check($sformatf("md5_go_c%0d", k), {31'd0, md_go}, (k == 1) ? 32'd1 : 32'd0);
            check($sformatf("md5_exmem_c%0d", k), {31'd0, EX_MEM_Stall}, 32'd0);
        end
        set_in(0, 0, 0, 0, 0, 0);
        check("md5_stall_total", pc_cnt, 6);
        check("md5_run_after", {25'd0, outs}, 32'd0);
        check("md5_stall_cycles", {16'd0, stall_cycles}, 32'd6);
        check("md5_no_err", {31'd0, md_err}, 32'd0);
        check("md5_go_low", {31'd0, md_go}, 32'd0);

        // MD_WAIT with mem_busy for 3 cycles, md_done in the 2nd
        do_reset();
        set_in(0, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 1, 0);
        check("mdmem_exmem1", {31'd0, EX_MEM_Stall}, 32'd1);
        check("mdmem_go1", {31'd0, md_go}, 32'd1);
        set_in(0, 0, 0, 1, 1, 0);
        check("mdmem_exmem2", {31'd0, EX_MEM_Stall}, 32'd1);
        check("mdmem_go2", {31'd0, md_go}, 32'd0);
        set_in(0, 0, 0, 0, 1, 0);
        check("mdmem_outs3", {25'd0, outs}, {25'd0, 7'b1111000});
        set_in(0, 0, 0, 0, 0, 0);
        check("mdmem_outs4", {25'd0, outs}, {25'd0, 7'b1110000});
        set_in(0, 0, 0, 0, 0, 0);
        check("mdmem_run", {25'd0, outs}, 32'd0);
        check("mdmem_go_run", {31'd0, md_go}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0);
        check("mdmem_go_later", {31'd0, md_go}, 32'd0);

        // md_start with no md_done: timeout after 40 MD_WAIT cycles
        do_reset();
        set_in(0, 0, 1, 0, 0, 0);
        pc_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            set_in(0, 0, 0, 0, 0, 0);
            pc_cnt += int'(PcStall);
        end
        check("tmo_wait_cycles", pc_cnt, 40);
        check("tmo_err_before", {31'd0, md_err}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0);
        check("tmo_run", {25'd0, outs}, 32'd0);
        check("tmo_err_set", {31'd0, md_err}, 32'd1);
        set_in(0, 0, 0, 1, 0, 0);
        check("tmo_done_ignored", {25'd0, outs}, 32'd0);
        for (int k = 0; k < 5; k++) set_in(0, 0, 0, 0, 0, 0);
        check("tmo_err_held", {31'd0, md_err}, 32'd1);

        // Saturation of stall_cycles, then perf_clr while stalled
        do_reset();
        set_in(0, 0, 0, 0, 1, 0);
        repeat (65540) @(posedge clk);
        @(negedge clk); #2;
        check("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
        check("sat_pcstall", {31'd0, PcStall}, 32'd1);
        set_in(0, 0, 0, 0, 1, 1);
        set_in(0, 0, 0, 0, 1, 0);
        check("clr_wins", {16'd0, stall_cycles}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0);
        check("clr_then_inc", {16'd0, stall_cycles}, 32'd1);

        // Reset asserted in the 3rd MEM_WAIT cycle
        do_reset();
        set_in(0, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 1, 0);
        set_in(0, 0, 0, 0, 1, 0);
        check("mrst_pre", {25'd0, outs}, {25'd0, 7'b1111001});
        #1 rst = 1'b1;
        #1;
        check("mrst_outs_async", {25'd0, outs}, 32'd0);
        check("mrst_cnt_async", {16'd0, stall_cycles}, 32'd0);
        @(negedge clk);
        mem_busy = 0;
        rst = 1'b0;
        #2;
        check("mrst_run", {25'd0, outs}, 32'd0);
        check("mrst_go", {31'd0, md_go}, 32'd0);

        // Reset mid-MD_WAIT: no md_go after release
        do_reset();
        set_in(0, 0, 1, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0);
        do_reset();
        #2;
        check("mdrst_run", {25'd0, outs}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0);
        check("mdrst_no_go", {31'd0, md_go}, 32'd0);

        // Randomized run against the reference model
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            model_reset();
            for (int n = 0; n < 1500; n++) begin
                bit h, b, s, d, m, c;
                logic [6:0] e;
                h = ($urandom_range(99) < 20);
                b = ($urandom_range(99) < 30);
                s = ($urandom_range(99) < 15);
                d = ($urandom_range(99) < ((phase == 0) ? 15 : 1));
                m = ($urandom_range(99) < ((phase == 0) ? 20 : 8));
                c = ($urandom_range(99) < 2);
                set_in(h, b, s, d, m, c);
                e = model_outs(h, b, s, m);
                check("rnd_outs", {25'd0, outs}, {25'd0, e});
                check("rnd_md_go", {31'd0, md_go}, {31'd0, m_go});
                check("rnd_md_err", {31'd0, md_err}, {31'd0, m_err});
                check("rnd_stall_cycles", {16'd0, stall_cycles}, m_cnt);
                model_edge(h, b, s, d, m, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 hdu_block  input  1  OR of load-use and branch-use hazard blocks from the hazard detection units.
REQ-004 branch_taken  input  1  ID-stage branch/jump resolved taken this cycle.
REQ-005 md_start  input  1  EX-stage instruction is a multi-cycle multiply/divide.
REQ-006 md_done  input  1  multiply/divide unit result valid; one-cycle pulse.
REQ-007 mem_busy  input  1  data memory cannot complete the MEM-stage access this cycle.
REQ-008 perf_clr  input  1  synchronous clear of stall_cycles.
REQ-009 PcStall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall  output  1 each  hold the PC or the named pipeline register.
REQ-010 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  output  1 each  load a bubble into the named register.
REQ-011 md_go  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-012 md_err  output  1  sticky multiply/divide timeout flag.
REQ-013 stall_cycles  output  16  saturating count of cycles with PcStall=1.

Function
REQ-014 The FSM SHALL have exactly three states: RUN, MD_WAIT, MEM_WAIT.
REQ-015 In RUN, outputs SHALL be combinational from inputs with priority mem_busy > md_start > hdu_block > branch_taken.
REQ-016 RUN with mem_busy=1: assert PcStall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall and MEM_WB_Flush; next state MEM_WAIT.
REQ-017 RUN with md_start=1 and mem_busy=0: assert PcStall, IF_ID_Stall, ID_EX_Stall; next state MD_WAIT; md_go=1 in the first MD_WAIT cycle only.
REQ-018 RUN with hdu_block=1 and no higher-priority source: assert PcStall, IF_ID_Stall, ID_EX_Flush; IF_ID_Flush=0 even if branch_taken=1; state stays RUN.
REQ-019 RUN with only branch_taken=1: assert IF_ID_Flush for that cycle only; state stays RUN.
REQ-020 MEM_WAIT: assert the REQ-016 set every cycle; return to RUN in the cycle after mem_busy is sampled 0; REQ-015..019 are ignored while in MEM_WAIT.
REQ-021 MD_WAIT: assert PcStall, IF_ID_Stall, ID_EX_Stall every cycle, plus EX_MEM_Flush-equivalent MEM_WB_Flush=0 and EX_MEM_Stall=mem_busy.
REQ-022 An md_done received while mem_busy=1 in MD_WAIT SHALL set an internal done_pend bit. The exit to RUN then occurs on the first cycle with mem_busy=0.
REQ-023 MD_WAIT SHALL exit to RUN on the edge where md_done (or done_pend) is 1 and mem_busy=0. On the RUN cycle that follows, stall outputs follow REQ-015 only.
REQ-024 A 6-bit md_timer SHALL clear on MD_WAIT entry and increment each MD_WAIT cycle. When it reaches MD_TIMEOUT (40) without done, md_err SHALL set and the FSM SHALL return to RUN.
REQ-025 md_err SHALL remain set until reset; md_done seen outside MD_WAIT SHALL be ignored.
REQ-026 stall_cycles SHALL increment by 1 on each edge where PcStall=1, saturate at 16'hFFFF, and clear on perf_clr. perf_clr SHALL win over increment in the same cycle.

Reset
REQ-027 On rst=1, immediately: state=RUN, done_pend=0, md_timer=0, md_go=0, md_err=0, stall_cycles=0. In RUN, all stall/flush outputs SHALL be 0 when all inputs are 0.
REQ-028 An rst asserted mid-MD_WAIT or mid-MEM_WAIT SHALL abandon the wait with no md_go re-issue after release.

Structure
REQ-029 The state encodings (RUN=2'd0, MD_WAIT=2'd1, MEM_WAIT=2'd2) and MD_TIMEOUT SHALL reside in the shared pipeline definitions include.
REQ-030 The saturating counter SHALL be a sub-module perf_counter (width parameter, clr, inc, count); everything else SHALL be flat.

Verification
REQ-031 RUN, hdu_block=1 and branch_taken=1 together -> PcStall=IF_ID_Stall=ID_EX_Flush=1, IF_ID_Flush=0, state RUN.
REQ-032 md_start=1 for one cycle, md_done 5 cycles later -> md_go pulses once, 6 stall cycles total, RUN after md_done, stall_cycles=6.
REQ-033 In MD_WAIT, mem_busy=1 for 3 cycles with md_done in the 2nd -> EX_MEM_Stall high 3 cycles, exit to RUN after mem_busy falls, md_go not repeated.
REQ-034 md_start with no md_done -> md_err=1 after 40 MD_WAIT cycles, state RUN, md_err held.
REQ-035 PcStall held for 70000 cycles -> stall_cycles=16'hFFFF; perf_clr with PcStall=1 -> 0.
REQ-036 rst asserted in the 3rd MEM_WAIT cycle -> all outputs 0 asynchronously, state RUN, stall_cycles=0.
